reg_cmd_master: RTL

- Byte-stream command decoder and register-bus initiator.
- Sits between a serial link's byte receiver/transmitter (UART/SPI byte layer) and the register file's address/writeEnable/writeData/readEnable/writeAdmin/readData/writeAck interface.
- Converts host command packets into single register read or write transactions.
- Returns read data or a status byte on the tx byte stream.

---
 rtl/reg_cmd_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/reg_cmd_master.sv
// Byte-stream command decoder that turns host packets into single register-bus
// read/write transactions and returns read data or a status byte on tx.
module reg_cmd_master #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 4,
   parameter int unsigned ACK_TIMEOUT  = 16,
   parameter int unsigned BYTE_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   output logic                  tx_valid,
   output logic [7:0]            tx_data,
   input  logic                  tx_ready,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  writeEnable,
   output logic [DATA_WIDTH-1:0] writeData,
   output logic                  writeAdmin,
   output logic                  readEnable,
   input  logic [DATA_WIDTH-1:0] readData,
   input  logic                  writeAck,
   output logic                  busy
);

   localparam int unsigned NBytes = DATA_WIDTH / 8;
   localparam int unsigned BcW    = $clog2(NBytes + 1);
   localparam int unsigned IcW    = $clog2(BYTE_TIMEOUT + 1);
   localparam int unsigned AcW    = $clog2(ACK_TIMEOUT + 1);

   localparam logic [BcW-1:0] ByteLast   = BcW'(NBytes - 1);
   localparam logic [IcW-1:0] IdleLast   = IcW'(BYTE_TIMEOUT - 1);
   // Timeout is counted from the strobe cycle, so WACK itself lasts ACK_TIMEOUT-1 cycles.
   localparam logic [AcW-1:0] AckLast    = AcW'((ACK_TIMEOUT > 2) ? ACK_TIMEOUT - 2 : 0);
   localparam logic [3:0]     AddrHiMask = 4'(15 << ADDR_WIDTH);

   typedef enum logic [2:0] {
      StIdle, StWdata, StWrite, StWack, StRead, StRcap, StTxd, StStat
   } state_e;

   state_e                state_q;
   logic                  admin_q;
   logic [BcW-1:0]        byte_cnt_q;
   logic [IcW-1:0]        idle_cnt_q;
   logic [AcW-1:0]        ack_cnt_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] shift_nxt;
   logic                  rx_fire;
   logic                  tx_fire;
   logic                  cmd_bad;

   assign rx_ready  = (state_q == StIdle) || (state_q == StWdata);
   assign busy      = (state_q != StIdle);
   assign rx_fire   = rx_valid && rx_ready;
   assign tx_fire   = tx_valid && tx_ready;
   assign cmd_bad   = (|rx_data[5:4]) || (|(rx_data[3:0] & AddrHiMask));
   assign shift_nxt = shift_q << 8;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StIdle;
         admin_q     <= 1'b0;
         byte_cnt_q  <= '0;
         idle_cnt_q  <= '0;
         ack_cnt_q   <= '0;
         shift_q     <= '0;
         tx_valid    <= 1'b0;
         tx_data     <= 8'h00;
         address     <= '0;
         writeEnable <= 1'b0;
         writeData   <= '0;
         writeAdmin  <= 1'b0;
         readEnable  <= 1'b0;
      end else begin
         writeEnable <= 1'b0;
         readEnable  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (rx_fire) begin
                  if (cmd_bad) begin
                     tx_valid <= 1'b1;
                     tx_data  <= 8'hEE;
                     state_q  <= StStat;
                  end else if (rx_data[7]) begin
                     address    <= rx_data[ADDR_WIDTH-1:0];
                     admin_q    <= rx_data[6];
                     byte_cnt_q <= '0;
                     idle_cnt_q <= '0;
                     state_q    <= StWdata;
                  end else begin
                     address    <= rx_data[ADDR_WIDTH-1:0];
                     readEnable <= 1'b1;
                     state_q    <= StRead;
                  end
               end
            end
            StWdata: begin
               if (rx_fire) begin
                  writeData  <= (writeData << 8) | DATA_WIDTH'(rx_data);
                  idle_cnt_q <= '0;
                  if (byte_cnt_q == ByteLast) begin
                     writeEnable <= 1'b1;
                     writeAdmin  <= admin_q;
                     state_q     <= StWrite;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                  end
               end else if (idle_cnt_q == IdleLast) begin
                  tx_valid <= 1'b1;
                  tx_data  <= 8'hE2;
                  state_q  <= StStat;
               end else begin
                  idle_cnt_q <= idle_cnt_q + 1'b1;
               end
            end
            StWrite: begin
               writeAdmin <= 1'b0;
               ack_cnt_q  <= '0;
               state_q    <= StWack;
            end
            StWack: begin
               if (writeAck) begin
                  tx_valid <= 1'b1;
                  tx_data  <= 8'hA5;
                  state_q  <= StStat;
               end else if (ack_cnt_q >= AckLast) begin
                  tx_valid <= 1'b1;
                  tx_data  <= 8'hE1;
                  state_q  <= StStat;
               end else begin
                  ack_cnt_q <= ack_cnt_q + 1'b1;
               end
            end
            StRead: state_q <= StRcap;
            StRcap: begin
               shift_q    <= readData;
               tx_valid   <= 1'b1;
               tx_data    <= readData[DATA_WIDTH-1 -: 8];
               byte_cnt_q <= '0;
               state_q    <= StTxd;
            end
            StTxd: begin
               if (tx_fire) begin
                  if (byte_cnt_q == ByteLast) begin
                     tx_valid <= 1'b0;
                     state_q  <= StIdle;
                  end else begin
                     shift_q    <= shift_nxt;
                     tx_data    <= shift_nxt[DATA_WIDTH-1 -: 8];
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                  end
               end
            end
            StStat: begin
               if (tx_fire) begin
                  tx_valid <= 1'b0;
                  state_q  <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
